// File: rtl/alu_seq_if.sv
// Request/completion bus of the ALU issue/writeback sequencer.
// The requester drives the operation fields and holds them while req_ready is low.
// The sequencer answers with req_ready, a one-cycle done strobe and the written-back result.
interface alu_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [1:0] req_ra;
  logic [1:0] req_rb;
  logic [1:0] req_rd;
  logic       done;
  logic [7:0] result;

  modport master (
    output req_valid, req_op, req_ra, req_rb, req_rd,
    input  req_ready, done, result
  );

  modport slave (
    input  req_valid, req_op, req_ra, req_rb, req_rd,
    output req_ready, done, result
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: issue/writeback sequencer placed in front of a two-stage registered 8-bit ALU.
// It reads operands from a 4 x 8-bit register file and issues them to the ALU.
// It waits out the ALU's two-register latency, then writes alu_o back to rf[rd].
// Optional feature macro ALU_SEQ_ILLEGAL_OP_EN: opcodes 0010-0111 are sequenced
// but never written back, and an extra err output pulses together with done.
module alu_seq (
  input  logic       ck,
  input  logic       rst,
  alu_seq_if.slave   req,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_ctr,
  input  logic [7:0] alu_o,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data
`ifdef ALU_SEQ_ILLEGAL_OP_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LAT1 = 2'd1,
    LAT2 = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       accept;
  logic       wb;
  logic       wr_en;
  logic       ready;
  logic       done_q;
  logic [7:0] result_q;
  logic [1:0] rd_q;
  logic [7:0] rf [4];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake decode: IDLE waits for a request, then three fixed latency steps.
  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    accept  = 1'b0;
    wb      = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req.req_valid) begin
          accept  = 1'b1;
          state_d = LAT1;
        end
      end
      LAT1:    state_d = LAT2;
      LAT2:    state_d = WB;
      WB: begin
        wb      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // alu_ctr holds the in-flight opcode until the next accept, so it doubles as the opcode tag at WB.
`ifdef ALU_SEQ_ILLEGAL_OP_EN
  logic illegal_op;
  assign illegal_op = (alu_ctr inside {[4'h2:4'h7]});
  assign wr_en      = wb && !illegal_op;
`else
  assign wr_en      = wb;
`endif

  // Operand issue: capture source registers (pre-edge rf contents) and opcode on the accept edge.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      alu_a   <= 8'h00;
      alu_b   <= 8'h00;
      alu_ctr <= 4'h0;
      rd_q    <= 2'd0;
    end else if (accept) begin
      alu_a   <= rf[req.req_ra];
      alu_b   <= rf[req.req_rb];
      alu_ctr <= req.req_op;
      rd_q    <= req.req_rd;
    end
  end

  // Register file: direct loads in any state, plus the ALU writeback.
  // When both target the same entry on one edge, the later writeback assignment wins.
  // NOTE: the register file is small and its reset contents are architecturally visible, so it is reset explicitly.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else begin
      if (ld_en) rf[ld_addr] <= ld_data;
      if (wr_en) rf[rd_q]    <= alu_o;
    end
  end

  // Completion: done pulses for one cycle after every WB edge; result tracks the last real writeback.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      done_q   <= 1'b0;
      result_q <= 8'h00;
    end else begin
      done_q <= wb;
      if (wr_en) result_q <= alu_o;
    end
  end

`ifdef ALU_SEQ_ILLEGAL_OP_EN
  // Error strobe: pulses alongside done only for opcodes that were suppressed at WB.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= wb && illegal_op;
  end
`endif

  assign req.req_ready = ready;
  assign req.done      = done_q;
  assign req.result    = result_q;
  assign rd_data       = rf[rd_addr];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq.
// A behavioural two-stage ALU sits behind the sequencer. A register-file model
// predicts every writeback from the operation rules: operands are read before the
// accept edge, and a writeback beats a direct load to the same register.
module tb_alu_seq;
  logic       ck;
  logic       rst;
  logic [7:0] alu_a, alu_b, alu_o;
  logic [3:0] alu_ctr;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
  logic       err;
`endif

  alu_seq_if bus ();

  alu_seq dut (
    .ck      (ck),
    .rst     (rst),
    .req     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_ctr (alu_ctr),
    .alu_o   (alu_o),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    ,
    .err     (err)
`endif
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // ALU function. Opcodes 0010-0111 are undefined and yield zero.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    case (c)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h8:    return a & b;
      4'h9:    return a | b;
      4'hA:    return a ^ b;
      4'hB:    return ~a;
      4'hC:    return a >> 1;
      4'hD:    return a << 1;
      4'hE:    return {a[0], a[7:1]};
      4'hF:    return {a[6:0], a[7]};
      default: return 8'h00;
    endcase
  endfunction

  // Two-register ALU: operands captured at one edge, result registered at the next.
  logic [7:0] s_a, s_b;
  logic [3:0] s_c;
  always @(posedge ck) begin
    s_a   <= alu_a;
    s_b   <= alu_b;
    s_c   <= alu_ctr;
    alu_o <= alu_fn(s_a, s_b, s_c);
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] rf_m [4];
  logic [7:0] res_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic check_rf(input string tag);
    logic [7:0] v;
    for (int r = 0; r < 4; r++) begin
      peek(r[1:0], v);
      check($sformatf("%s_rf%0d", tag, r), v, rf_m[r]);
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    @(negedge ck);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge ck);
    ld_en = 1'b0;
    rf_m[a] = d;
  endtask

  function automatic bit op_legal(input logic [3:0] op);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    return !(op inside {[4'h2:4'h7]});
`else
    return 1'b1;
`endif
  endfunction

  // One full operation. ld_at: 0 = no load, 1 = load on accept edge, 4 = load on WB edge.
  task automatic run_op(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [1:0] rd, input int ld_at, input logic [1:0] la,
                        input logic [7:0] ldd, input bit use_c, input logic [7:0] exp_c);
    logic [7:0] a_m, b_m, exp_r, v;
    bit         legal;
    int         lat;
    a_m   = rf_m[ra];
    b_m   = rf_m[rb];
    exp_r = alu_fn(a_m, b_m, op);
    legal = op_legal(op);
    lat   = 9;
    @(negedge ck);
    check("ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_ra = ra; bus.req_rb = rb; bus.req_rd = rd;
    if (ld_at == 1) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ldd;
    end
    @(posedge ck);
    #1;
    bus.req_valid = 1'b0;
    ld_en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge ck);
      if (k == 4) ld_en = 1'b0;
      if (k == 1) begin
        check("issue_a", alu_a, a_m);
        check("issue_b", alu_b, b_m);
        check("issue_ctr", alu_ctr, op);
        check("ready_busy", bus.req_ready, 0);
      end
      if (bus.done) begin
        lat = k;
        break;
      end
      if (k == 3 && ld_at == 4) begin
        ld_en = 1'b1; ld_addr = la; ld_data = ldd;
      end
    end
    ld_en = 1'b0;
    check("done_latency", lat, 4);
    if (ld_at != 0) rf_m[la] = ldd;
    if (legal) begin
      rf_m[rd] = exp_r;
      res_m    = exp_r;
    end
    check("result", bus.result, res_m);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    check("err_pulse", err, !legal);
`endif
    if (use_c) begin
      peek(rd, v);
      check("rd_const", v, exp_c);
    end
    @(negedge ck);
    check("done_single", bus.done, 0);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    check("err_single", err, 0);
`endif
    check_rf("op");
  endtask

  typedef struct {
    logic [3:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] rd;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] rdy_bits, dn_bits;
    logic [7:0]  v, exp_ill;
    bit          dn;

    tbl[0] = '{4'h0, 2'd0, 2'd1, 2'd2, 8'h4B};
    tbl[1] = '{4'h1, 2'd2, 2'd1, 2'd3, 8'h3C};
    tbl[2] = '{4'h8, 2'd0, 2'd1, 2'd1, 8'h0C};
    tbl[3] = '{4'hA, 2'd2, 2'd2, 2'd2, 8'h00};
    tbl[4] = '{4'h9, 2'd1, 2'd3, 2'd0, 8'h3C};
    tbl[5] = '{4'hB, 2'd1, 2'd0, 2'd2, 8'hF3};
    tbl[6] = '{4'hC, 2'd2, 2'd0, 2'd1, 8'h79};
    tbl[7] = '{4'hF, 2'd2, 2'd2, 2'd3, 8'hE7};

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 4'h0; bus.req_ra = 2'd0; bus.req_rb = 2'd0; bus.req_rd = 2'd0;
    ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'h00; rd_addr = 2'd0;
    for (int r = 0; r < 4; r++) rf_m[r] = 8'h00;
    res_m = 8'h00;

    // Reset state.
    @(negedge ck);
    @(negedge ck);
    check("rst_ready", bus.req_ready, 1);
    check("rst_done", bus.done, 0);
    rst = 1'b0;
    @(negedge ck);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_ctr", alu_ctr, 4'h0);
    check("rst_result", bus.result, 8'h00);
    check("rst_ready_after", bus.req_ready, 1);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    check("rst_err", err, 0);
`endif
    check_rf("rst");

    // Table of dependent operations.
    load(2'd0, 8'h3C);
    load(2'd1, 8'h0F);
    for (int i = 0; i < 8; i++)
      run_op(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].rd, 0, 2'd0, 8'h00, 1'b1, tbl[i].exp);

    // Rotate right then shift left in place.
    load(2'd0, 8'h81);
    run_op(4'hE, 2'd0, 2'd0, 2'd0, 0, 2'd0, 8'h00, 1'b1, 8'hC0);
    run_op(4'hD, 2'd0, 2'd0, 2'd0, 0, 2'd0, 8'h00, 1'b1, 8'h80);

    // Load and writeback to the same register on one edge: writeback wins.
    load(2'd0, 8'hAA);
    run_op(4'h9, 2'd0, 2'd0, 2'd3, 4, 2'd3, 8'h55, 1'b1, 8'hAA);
    // Load and writeback to different registers on one edge: both land.
    run_op(4'h9, 2'd0, 2'd0, 2'd3, 4, 2'd1, 8'h5A, 1'b1, 8'hAA);
    peek(2'd1, v);
    check("wb_ld_other", v, 8'h5A);
    // Load to a source register on the accept edge: old value is used.
    load(2'd1, 8'h11);
    run_op(4'h0, 2'd1, 2'd1, 2'd2, 1, 2'd1, 8'h22, 1'b1, 8'h22);
    peek(2'd1, v);
    check("accept_ld_landed", v, 8'h22);

    // Back-to-back requests held valid.
    load(2'd0, 8'h07);
    @(negedge ck);
    bus.req_valid = 1'b1; bus.req_op = 4'h0; bus.req_ra = 2'd0; bus.req_rb = 2'd0; bus.req_rd = 2'd3;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge ck);
      rdy_bits[12-i] = bus.req_ready;
      dn_bits[12-i]  = bus.done;
      if (i == 9) bus.req_valid = 1'b0;
    end
    check("b2b_ready", rdy_bits, 13'b1000100010001);
    check("b2b_done", dn_bits, 13'b0000100010001);
    rf_m[3] = alu_fn(rf_m[0], rf_m[0], 4'h0);
    res_m   = rf_m[3];
    check("b2b_result", bus.result, res_m);
    check_rf("b2b");

    // Reset during LAT2 aborts the operation.
    @(negedge ck);
    bus.req_valid = 1'b1; bus.req_op = 4'h0; bus.req_ra = 2'd0; bus.req_rb = 2'd1; bus.req_rd = 2'd2;
    @(posedge ck);
    #1;
    bus.req_valid = 1'b0;
    @(negedge ck);
    @(negedge ck);
    rst = 1'b1;
    #1;
    check("midrst_ready", bus.req_ready, 1);
    @(negedge ck);
    rst = 1'b0;
    dn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ck);
      dn = dn | bus.done;
    end
    check("midrst_no_done", dn, 0);
    for (int r = 0; r < 4; r++) rf_m[r] = 8'h00;
    res_m = 8'h00;
    check("midrst_alu_a", alu_a, 8'h00);
    check("midrst_alu_ctr", alu_ctr, 4'h0);
    check("midrst_result", bus.result, 8'h00);
    check_rf("midrst");
    load(2'd0, 8'h05);
    load(2'd1, 8'h03);
    run_op(4'h0, 2'd0, 2'd1, 2'd2, 0, 2'd0, 8'h00, 1'b1, 8'h08);

    // Undefined opcode writeback behaviour.
    load(2'd2, 8'h77);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    exp_ill = 8'h77;
`else
    exp_ill = 8'h00;
`endif
    run_op(4'h3, 2'd0, 2'd1, 2'd2, 0, 2'd0, 8'h00, 1'b1, exp_ill);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      int          sel;
      logic [1:0]  la;
      logic [7:0]  ldd;
      if ($urandom_range(0, 2) == 0) load(2'($urandom_range(0, 3)), 8'($urandom));
      sel = $urandom_range(0, 2);
      la  = 2'($urandom_range(0, 3));
      ldd = 8'($urandom);
      run_op(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), (sel == 0) ? 0 : (sel == 1) ? 1 : 4, la, ldd, 1'b0, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Issue/writeback sequencer directly upstream of the two-stage registered 8-bit ALU. It accepts operation requests over a valid/ready handshake and reads operands from a 4-entry × 8-bit register file. It drives the ALU's A/B/CTR inputs, waits out the ALU's two-register latency, and writes the ALU result back into the register file. It also pulses a completion strobe with the result.

## Interface
Parameters:
- none. Widths are fixed: 8-bit data, 4-bit opcode, 4 registers.

Ports:
- ck  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept; high only in IDLE
- req_op  input  4  ALU opcode, passed unchanged to alu_ctr
- req_ra  input  2  source register for A
- req_rb  input  2  source register for B
- req_rd  input  2  destination register
- alu_a  output  8  registered operand A to ALU
- alu_b  output  8  registered operand B to ALU
- alu_ctr  output  4  registered opcode to ALU
- alu_o  input  8  ALU registered result
- done  output  1  one-cycle pulse, writeback just completed
- result  output  8  value written at last writeback; held until next writeback
- ld_en  input  1  direct register load strobe
- ld_addr  input  2  load address
- ld_data  input  8  load data
- rd_addr  input  2  observation read address
- rd_data  output  8  combinational read of rf[rd_addr]

## Operation
- States: IDLE, LAT1, LAT2, WB.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, the request is accepted.
  - alu_a<=rf[req_ra], alu_b<=rf[req_rb], alu_ctr<=req_op; rd latched internally.
  - Next state LAT1.
- LAT1 -> LAT2 -> WB unconditionally. The ALU captures its operands at the LAT1 edge and updates O at the LAT2 edge.
- WB:
  - At the next edge: rf[rd]<=alu_o, result<=alu_o, done<=1 for one cycle.
  - Next state IDLE.
- alu_a/alu_b/alu_ctr hold their values outside the accept edge.
- Operand read uses pre-edge rf contents. An ld_en to a source register on the accept edge is not seen by that request.
- ld_en is honoured in any state.
- If ld_en and the WB write target the same register on the same edge, the WB write wins. Different registers are both written.
- rd_addr/rd_data is purely combinational and has no side effects.
- ra, rb and rd may all alias. Results use the operands captured at accept.
- Requests presented while req_ready=0 are ignored. The requester must hold them.

## Timing
- Accept edge = E0. ALU captures at E1, alu_o valid after E2, writeback/result/done at E3.
- done is high for the cycle after E3.
- Throughput is one operation per 4 cycles. A new request may be accepted at E4, the first edge with state IDLE. req_ready rises in the same cycle done is high.
- Reset (async, any time):
  - state=IDLE; rf all 0x00; alu_a=alu_b=0x00; alu_ctr=4'b0000; result=0x00; done=0.
  - A reset mid-operation aborts it: no writeback and no done.
  - req_ready=1 during and after reset.

## Configuration
- ALU_SEQ_ILLEGAL_OP_EN defined:
  - Opcodes 0010–0111 are accepted and sequenced normally, but the WB edge does not write rf and does not update result.
  - done still pulses.
  - An extra output err (1 bit, reset 0) pulses with done for illegal opcodes only.
- Undefined:
  - All opcodes are written back. The ALU yields 0x00 for undefined codes, so rf[rd] becomes 0x00.
  - The err port is absent.

## Test plan
- Reset, then load rf0=0x3C, rf1=0x0F. Request op 0000, ra=0, rb=1, rd=2. -> alu_a=0x3C, alu_b=0x0F after E0; done at E3+; rf2=0x4B, result=0x4B.
- Back-to-back requests held valid continuously. -> accepts exactly every 4 cycles; req_ready low in LAT1/LAT2/WB.
- rf0=0x81, op 1110 (rotate right), ra=rd=0. -> rf0=0xC0. Then op 1101 (shift left), ra=rd=0. -> rf0=0x80.
- Load rf3=0x55 on the same edge as a WB to rd=3 with result 0xAA. -> rf3=0xAA. Load to rf1 on the accept edge of a request with ra=1 -> the old rf1 value is used.
- Assert rst during LAT2. -> no done; rf all 0x00; state IDLE; next request completes normally.
- Op 0011, rd=2, rf2=0x77. -> with ALU_SEQ_ILLEGAL_OP_EN: rf2 stays 0x77, err and done pulse. Without it: rf2=0x00, done pulses.
